// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch-entry type for the fetch stage
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; DEPTH must be a power of two
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage with prefetch buffer; IFU_MISALIGN_CHECK_EN adds misaligned-redirect trap
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instruction,
    output logic [XLEN-1:0] id_pc_next
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misaligned
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            req_hs, rsp_drop, rsp_keep, id_pop, fetch_block;
    logic [XLEN-1:0] redirect_tgt, aq_head;
    logic [CW-1:0]   pf_count, aq_count;
    logic [CW:0]     occupancy;
    logic            pf_empty, pf_full, aq_empty, aq_full;
    fetch_entry_t    pf_wdata, pf_head;
    logic            unused_fifo;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign redirect_tgt     = redirect_pc;
    assign fetch_block      = misaligned_q;
    assign fetch_misaligned = misaligned_q;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) misaligned_d = (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) misaligned_q <= 1'b0;
        else        misaligned_q <= misaligned_d;
    end
`else
    logic unused_pc_lsb;

    assign redirect_tgt  = {redirect_pc[XLEN-1:2], 2'b00};
    assign fetch_block   = 1'b0;
    assign unused_pc_lsb = ^redirect_pc[1:0];
`endif

    assign id_valid = !pf_empty;
    assign id_pop   = id_valid && id_ready;

    // Credit the slot freed by this cycle's pop so BUF_DEPTH=2 sustains one per cycle.
    assign occupancy      = {1'b0, outstanding_q} + {1'b0, pf_count} - {{CW{1'b0}}, id_pop};
    assign imem_req_valid = rst_n && !fetch_block && (occupancy < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = redirect_tgt;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_hs) pc_d = pc_q + 32'd4;
            if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Address queue only tracks requests that survive the last redirect.
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN)) u_addr_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_hs && !redirect_valid),
        .pop   (rsp_keep),
        .flush (redirect_valid),
        .wdata (pc_q),
        .rdata (aq_head),
        .full  (aq_full),
        .empty (aq_empty),
        .count (aq_count)
    );

    assign pf_wdata = '{pc: aq_head, instruction: imem_rsp_data};

    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(fetch_entry_t))) u_prefetch (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .pop   (id_pop),
        .flush (redirect_valid),
        .wdata (pf_wdata),
        .rdata (pf_head),
        .full  (pf_full),
        .empty (pf_empty),
        .count (pf_count)
    );

    assign unused_fifo    = ^{aq_full, aq_empty, aq_count, pf_full};
    assign id_pc          = pf_empty ? '0 : pf_head.pc;
    assign id_instruction = pf_empty ? NOP_INSTR : pf_head.instruction;
    assign id_pc_next     = id_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] SIG      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_pc, id_instruction, id_pc_next;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_pc_next     (id_pc_next)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: in-order responses with per-request latency, data = addr ^ SIG.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int  cyc = 0, last_due = 0, hs_count = 0;
    int  lat_min = 1, lat_max = 1, ready_pct = 100, idr_pct = 100, redir_pct = 0;
    bit  hold_rst = 1'b1, coincide_mode = 1'b0;
    int  coincide_seen = 0;

    function automatic logic [31:0] rand_target();
`ifdef IFU_MISALIGN_CHECK_EN
        return $urandom & 32'hFFFF_FFFC;
`else
        return $urandom;
`endif
    endfunction

    task automatic step(input bit redir = 1'b0, input logic [31:0] tgt = '0);
        int due;
        @(negedge clk);
        cyc++;
        rst_n = !hold_rst;
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].addr ^ SIG;
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        id_ready       = ($urandom_range(0, 99) < idr_pct);
        if (!redir && rst_n && $urandom_range(0, 99) < redir_pct) begin
            redir = 1'b1;
            tgt   = rand_target();
        end
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : $urandom;
        #1;
        if (coincide_mode && !redir && imem_rsp_valid && imem_req_valid && imem_req_ready) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0400;
            coincide_seen++;
            coincide_mode  = 1'b0;
        end
        if (!rst_n) begin
            mem_q.delete();
            last_due = cyc;
        end else if (imem_req_valid && imem_req_ready) begin
            hs_count++;
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due});
        end
    endtask

    // Scoreboard: decode must see the sequential stream starting at the last redirect target.
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] redir_tgt_s = '0;
    bit          post_redir = 1'b0;
    bit          exp_mis = 1'b0;
    int          rst_low = 0, pop_count = 0;

    function automatic logic [31:0] tgt_of(input logic [31:0] t);
`ifdef IFU_MISALIGN_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic restart(input logic [31:0] base);
        exp_pc_q.delete();
        for (int i = 0; i < 8; i++) exp_pc_q.push_back(base + 32'(4 * i));
        exp_req = base;
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            if (rst_low > 0) begin
                check("rst_req_valid", imem_req_valid, 1'b0);
                check("rst_id_valid", id_valid, 1'b0);
                check("rst_id_pc", id_pc, 32'h0);
                check("rst_id_instr", id_instruction, NOP);
                check("rst_id_pc_next", id_pc_next, 32'h4);
`ifdef IFU_MISALIGN_CHECK_EN
                check("rst_misaligned", fetch_misaligned, 1'b0);
`endif
            end
            rst_low++;
            restart(RESET_PC);
            post_redir = 1'b0;
            exp_mis    = 1'b0;
        end else begin
            rst_low = 0;
            if (post_redir) begin
                check("redir_id_valid", id_valid, 1'b0);
                check("redir_req_addr", imem_req_addr, redir_tgt_s);
                post_redir = 1'b0;
            end
`ifdef IFU_MISALIGN_CHECK_EN
            check("misaligned_flag", fetch_misaligned, exp_mis);
            if (exp_mis) check("misaligned_no_req", imem_req_valid, 1'b0);
`endif
            if (!id_valid) begin
                check("idle_pc", id_pc, 32'h0);
                check("idle_instr", id_instruction, NOP);
            end else if (id_ready && !redirect_valid) begin
                check("id_pc", id_pc, exp_pc_q[0]);
                check("id_instr", id_instruction, exp_pc_q[0] ^ SIG);
                check("id_pc_next", id_pc_next, exp_pc_q[0] + 32'd4);
                void'(exp_pc_q.pop_front());
                while (exp_pc_q.size() < 4) exp_pc_q.push_back(exp_pc_q[$] + 32'd4);
                pop_count++;
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
            end
            if (redirect_valid) begin
                redir_tgt_s = tgt_of(redirect_pc);
                restart(redir_tgt_s);
                post_redir = 1'b1;
                exp_mis    = (redirect_pc[1:0] != 2'b00);
            end
        end
    end

    task automatic do_reset(input int n);
        hold_rst = 1'b1;
        repeat (n) step();
        hold_rst = 1'b0;
    endtask

    initial begin
        int p0, h0, n;
        do_reset(3);

        // Zero-wait memory, decode always ready: first request and full throughput.
        lat_min = 1; lat_max = 1; ready_pct = 100; idr_pct = 100;
        step();
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        repeat (4) step();
        p0 = pop_count;
        repeat (20) step();
        check("throughput", 32'(pop_count - p0), 32'd20);

        // Decode stalled: only BUF_DEPTH requests go out, nothing lost afterwards.
        do_reset(2);
        idr_pct = 0;
        h0 = hs_count;
        repeat (10) step();
        check("stall_req_count", 32'(hs_count - h0), 32'd2);
        check("stall_req_valid", imem_req_valid, 1'b0);
        p0 = pop_count;
        idr_pct = 100;
        repeat (10) step();
        check("stall_release", 32'(pop_count - p0 >= 2), 32'd1);

        // Redirect with two requests outstanding at latency 3.
        do_reset(2);
        lat_min = 3; lat_max = 3; idr_pct = 0;
        n = 0;
        while (mem_q.size() != 2 && n < 20) begin step(); n++; end
        check("two_outstanding", 32'(mem_q.size()), 32'd2);
        step(1'b1, 32'h0000_0100);
        idr_pct = 100;
        repeat (20) step();

        // Redirect coincident with a response and a request handshake.
        lat_min = 1; lat_max = 1;
        coincide_mode = 1'b1;
        n = 0;
        while (coincide_seen == 0 && n < 30) begin step(); n++; end
        check("coincide_seen", 32'(coincide_seen), 32'd1);
        repeat (20) step();

        // Wrap from the top of the address space.
        step(1'b1, 32'hFFFF_FFF8);
        repeat (20) step();

`ifdef IFU_MISALIGN_CHECK_EN
        step(1'b1, 32'h0000_0102);
        repeat (6) step();
        step(1'b1, 32'h0000_0200);
        repeat (20) step();
`else
        step(1'b1, 32'h0000_0302);
        repeat (20) step();
`endif

        // Randomized traffic with redirects and one mid-operation reset.
        lat_min = 1; lat_max = 4; ready_pct = 70; idr_pct = 60; redir_pct = 3;
        repeat (300) step();
        redir_pct = 0;
        do_reset(2);
        redir_pct = 3;
        repeat (300) step();
        redir_pct = 0;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
